// File: rtl/ahb3_master_sequencer_if.sv
// Command handshake and AHB-Lite bus signals shared between the
// sequencer (master) and the stimulus/slave side.
interface ahb3_master_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_write;
  logic [2:0]        cmd_size;
  logic [2:0]        cmd_burst;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] HADDR;
  logic [DATA_W-1:0] HWDATA;
  logic              HWRITE;
  logic [1:0]        HTRANS;
  logic [2:0]        HSIZE;
  logic [2:0]        HBURST;
  logic [DATA_W-1:0] HRDATA;
  logic              HREADY;
  logic              HRESP;

  modport master (
    input  cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_burst, wr_data,
           HRDATA, HREADY, HRESP,
    output cmd_ready, wr_ack, rd_data, rd_valid, done, err,
           HADDR, HWDATA, HWRITE, HTRANS, HSIZE, HBURST
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_burst, wr_data,
           HRDATA, HREADY, HRESP,
    input  cmd_ready, wr_ack, rd_data, rd_valid, done, err,
           HADDR, HWDATA, HWRITE, HTRANS, HSIZE, HBURST
  );
endinterface

// File: rtl/ahb3_master_sequencer.sv
// AHB-Lite master transfer sequencer: turns one command into pipelined
// NONSEQ/SEQ beats with wait-state hold and two-cycle ERROR abort.
module ahb3_master_sequencer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic HCLK,
  input logic HRESET,
  ahb3_master_sequencer_if.master bus
);
  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_W / 8));

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_BURST, S_LAST} state_e;
  typedef enum logic [1:0] {HT_IDLE = 2'b00, HT_NONSEQ = 2'b10, HT_SEQ = 2'b11} htrans_e;

  state_e            r_state, w_state;
  htrans_e           r_htrans, w_htrans;
  logic [ADDR_W-1:0] r_haddr, w_haddr;
  logic [DATA_W-1:0] r_hwdata, w_hwdata;
  logic [DATA_W-1:0] r_rd_data, w_rd_data;
  logic              r_hwrite, w_hwrite;
  logic [2:0]        r_hsize, w_hsize;
  logic [2:0]        r_hburst, w_hburst;
  logic [3:0]        r_left, w_left;
  logic              r_dphase, w_dphase;
  logic              r_rd_valid, w_rd_valid;
  logic              r_done, w_done;
  logic              r_err, w_err;
  logic              w_wr_ack;
  logic [ADDR_W-1:0] w_step, w_incr, w_wrap_mask, w_next_addr;

  function automatic logic [4:0] burst_beats(input logic [2:0] b);
    case (b[2:1])
      2'd0:    return 5'd1;
      2'd1:    return 5'd4;
      2'd2:    return 5'd8;
      default: return 5'd16;
    endcase
  endfunction

  // Wrapping bursts keep address bits above the burst span fixed.
  always_comb begin
    w_step      = ADDR_W'(1) << r_hsize;
    w_incr      = r_haddr + w_step;
    w_wrap_mask = (ADDR_W'(burst_beats(r_hburst)) << r_hsize) - ADDR_W'(1);
    if (r_hburst[0] || r_hburst == 3'b000)
      w_next_addr = w_incr;
    else
      w_next_addr = (r_haddr & ~w_wrap_mask) | (w_incr & w_wrap_mask);
  end

  always_comb begin
    w_state    = r_state;
    w_htrans   = r_htrans;
    w_haddr    = r_haddr;
    w_hwdata   = r_hwdata;
    w_hwrite   = r_hwrite;
    w_hsize    = r_hsize;
    w_hburst   = r_hburst;
    w_left     = r_left;
    w_dphase   = r_dphase;
    w_rd_data  = r_rd_data;
    w_rd_valid = 1'b0;
    w_done     = 1'b0;
    w_err      = 1'b0;
    w_wr_ack   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          w_haddr  = bus.cmd_addr;
          w_hwrite = bus.cmd_write;
          w_hsize  = (bus.cmd_size > MAX_SIZE) ? MAX_SIZE : bus.cmd_size;
          w_hburst = bus.cmd_burst;
          w_left   = 4'(burst_beats(bus.cmd_burst) - 5'd1);
          w_htrans = HT_NONSEQ;
          w_state  = S_ADDR;
        end
      end
      S_ADDR, S_BURST: begin
        // An error response cancels the pending address phase even while HREADY is low.
        if (r_dphase && bus.HRESP) begin
          w_htrans = HT_IDLE;
          if (bus.HREADY) begin
            w_dphase = 1'b0;
            w_done   = 1'b1;
            w_err    = 1'b1;
            w_state  = S_IDLE;
          end else begin
            w_state = S_LAST;
          end
        end else if (bus.HREADY) begin
          w_dphase = 1'b1;
          if (r_dphase && !r_hwrite) begin
            w_rd_valid = 1'b1;
            w_rd_data  = bus.HRDATA;
          end
          if (r_hwrite) begin
            w_wr_ack = 1'b1;
            w_hwdata = bus.wr_data;
          end
          if (r_left == 4'd0) begin
            w_htrans = HT_IDLE;
            w_state  = S_LAST;
          end else begin
            w_haddr  = w_next_addr;
            w_htrans = HT_SEQ;
            w_left   = r_left - 4'd1;
            w_state  = S_BURST;
          end
        end
      end
      S_LAST: begin
        if (bus.HREADY) begin
          w_dphase = 1'b0;
          w_htrans = HT_IDLE;
          w_done   = 1'b1;
          w_state  = S_IDLE;
          if (bus.HRESP) begin
            w_err = 1'b1;
          end else if (!r_hwrite) begin
            w_rd_valid = 1'b1;
            w_rd_data  = bus.HRDATA;
          end
        end
      end
      default: w_state = S_IDLE;
    endcase
    if (HRESET) w_wr_ack = 1'b0;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state    <= S_IDLE;
      r_htrans   <= HT_IDLE;
      r_haddr    <= '0;
      r_hwdata   <= '0;
      r_hwrite   <= 1'b0;
      r_hsize    <= '0;
      r_hburst   <= '0;
      r_left     <= '0;
      r_dphase   <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_htrans   <= w_htrans;
      r_haddr    <= w_haddr;
      r_hwdata   <= w_hwdata;
      r_hwrite   <= w_hwrite;
      r_hsize    <= w_hsize;
      r_hburst   <= w_hburst;
      r_left     <= w_left;
      r_dphase   <= w_dphase;
      r_rd_data  <= w_rd_data;
      r_rd_valid <= w_rd_valid;
      r_done     <= w_done;
      r_err      <= w_err;
    end
  end

  assign bus.cmd_ready = (r_state == S_IDLE);
  assign bus.wr_ack    = w_wr_ack;
  assign bus.rd_data   = r_rd_data;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.HADDR     = r_haddr;
  assign bus.HWDATA    = r_hwdata;
  assign bus.HWRITE    = r_hwrite;
  assign bus.HTRANS    = r_htrans;
  assign bus.HSIZE     = r_hsize;
  assign bus.HBURST    = r_hburst;
endmodule

// File: tb/tb_ahb3_master_sequencer.sv
// Bench for ahb3_master_sequencer: table-driven and random commands against
// an arithmetic address/beat model, plus reset and back-to-back sequences.
module tb_ahb3_master_sequencer;
  localparam int AW = 32;
  localparam int DW = 32;

  logic HCLK = 1'b0;
  logic HRESET;
  always #5 HCLK = ~HCLK;

  ahb3_master_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  ahb3_master_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [31:0] wbase;
    int          wbeat;
    int          wcyc;
    int          ebeat;
    int          exp_acc;
    logic [31:0] exp_last;
  } vec_t;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int beats_of(input logic [2:0] b);
    case (b)
      3'd0, 3'd1: return 1;
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      default:    return 16;
    endcase
  endfunction

  function automatic logic [2:0] eff_size(input logic [2:0] s);
    return (s > 3'd2) ? 3'd2 : s;
  endfunction

  function automatic logic [31:0] model_addr(input logic [31:0] start, input logic [2:0] size,
                                             input logic [2:0] burst, input int k);
    logic [31:0] step, span, base;
    step = 32'd1 << eff_size(size);
    if (burst == 3'd2 || burst == 3'd4 || burst == 3'd6) begin
      span = step * 32'(beats_of(burst));
      base = start - (start % span);
      return base + ((start - base + step * 32'(k)) % span);
    end
    return start + step * 32'(k);
  endfunction

  function automatic logic [31:0] rdat(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h3C3C_0000;
  endfunction

  function automatic logic [31:0] wdat(input logic [31:0] base, input int k);
    return base + 32'h0101_0101 * 32'(k);
  endfunction

  task automatic do_reset();
    HRESET = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_write = 1'b0;
    bus.cmd_size = '0; bus.cmd_burst = '0; bus.wr_data = '0;
    bus.HRDATA = '0; bus.HREADY = 1'b1; bus.HRESP = 1'b0;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where done shows.
  task automatic run_cmd(input vec_t v, input bit rnd, input bit keep, input vec_t nx);
    int beats, acc, rdn, wrn, cyc, wait_left, dp_beat, eph, exp_acc;
    bit dp_valid, exp_done, hold_chk, cancelled, exp_active, hr, hs;
    logic [31:0] pa, last_a;
    beats = beats_of(v.burst);
    exp_acc = (v.ebeat < 0) ? beats : v.ebeat + 1;
    acc = 0; rdn = 0; wrn = 0; cyc = 0; wait_left = 0; dp_beat = 0; eph = 0;
    dp_valid = 0; exp_done = 0; hold_chk = 0; cancelled = 0; pa = '0; last_a = '0;
    check1("cmd_ready_idle", bus.cmd_ready, 1'b1);
    bus.cmd_valid = 1'b1; bus.cmd_addr = v.addr; bus.cmd_write = v.write;
    bus.cmd_size = v.size; bus.cmd_burst = v.burst;
    bus.HREADY = 1'b1; bus.HRESP = 1'b0;
    @(posedge HCLK);
    @(negedge HCLK);
    if (keep) begin
      bus.cmd_addr = nx.addr; bus.cmd_write = nx.write;
      bus.cmd_size = nx.size; bus.cmd_burst = nx.burst;
    end else begin
      bus.cmd_valid = 1'b0; bus.cmd_addr = $urandom; bus.cmd_write = ~v.write;
      bus.cmd_size = 3'($urandom); bus.cmd_burst = 3'($urandom);
    end
    forever begin
      check1("cmd_ready", bus.cmd_ready, exp_done);
      check1("done", bus.done, exp_done);
      check1("err", bus.err, exp_done && v.ebeat >= 0);
      if (bus.rd_valid) begin
        check("rd_data", bus.rd_data, rdat(model_addr(v.addr, v.size, v.burst, rdn)));
        rdn++;
      end
      if (hold_chk) check("hold_haddr", bus.HADDR, pa);
      if (dp_valid && v.write) check("hwdata", bus.HWDATA, wdat(v.wbase, dp_beat));
      exp_active = (acc < beats) && !cancelled;
      if (!exp_done && !bus.done)
        check("htrans", 32'(bus.HTRANS), exp_active ? ((acc == 0) ? 32'd2 : 32'd3) : 32'd0);
      if (exp_done || bus.done) break;
      cyc++;
      if (cyc > 400) begin
        check1("timeout", 1'b1, 1'b0);
        break;
      end
      hr = 1'b1; hs = 1'b0; bus.HRDATA = $urandom;
      if (dp_valid) begin
        if (dp_beat == v.ebeat) begin
          hs = 1'b1; hr = (eph == 1); eph++;
        end else if (wait_left > 0) begin
          hr = 1'b0; wait_left--;
        end
        if (hr && !hs && !v.write) bus.HRDATA = rdat(model_addr(v.addr, v.size, v.burst, dp_beat));
      end
      bus.HREADY = hr; bus.HRESP = hs; bus.wr_data = wdat(v.wbase, acc);
      #1;
      check1("wr_ack", bus.wr_ack, exp_active && hr && v.write);
      if (bus.wr_ack) wrn++;
      if (dp_valid && hr) begin
        if (dp_beat == beats - 1 || hs) exp_done = 1'b1;
        dp_valid = 1'b0;
      end
      if (exp_active && hr) begin
        check("haddr", bus.HADDR, model_addr(v.addr, v.size, v.burst, acc));
        check("hsize", 32'(bus.HSIZE), 32'(eff_size(v.size)));
        check("hburst", 32'(bus.HBURST), 32'(v.burst));
        check1("hwrite", bus.HWRITE, v.write);
        last_a = bus.HADDR; dp_valid = 1'b1; dp_beat = acc;
        if (acc == v.wbeat) wait_left = v.wcyc;
        else if (rnd && $urandom_range(0, 3) == 0) wait_left = int'($urandom_range(1, 2));
        else wait_left = 0;
        acc++;
      end
      if (hs && !hr) cancelled = 1'b1;
      hold_chk = !hr && !hs;
      pa = bus.HADDR;
      @(negedge HCLK);
    end
    check("beats_accepted", 32'(acc), 32'(v.exp_acc));
    check("last_addr", last_a, v.exp_last);
    check("rd_count", 32'(rdn), v.write ? 32'd0 : 32'((v.ebeat < 0) ? beats : v.ebeat));
    check("wr_ack_count", 32'(wrn), v.write ? 32'(exp_acc) : 32'd0);
    bus.HREADY = 1'b1; bus.HRESP = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  initial begin
    vec_t r, b2b_a, b2b_b, single;
    //            addr      wr    sz    burst wbase          wbeat wcyc ebeat acc last
    tbl[0] = '{32'h40,  1'b1, 3'd2, 3'd0, 32'hDEAD_BEEF, -1, 0, -1, 1,  32'h40};
    tbl[1] = '{32'h100, 1'b0, 3'd2, 3'd3, 32'h0,          1, 2, -1, 4,  32'h10C};
    tbl[2] = '{32'h1C,  1'b1, 3'd2, 3'd2, 32'h1122_3344, -1, 0, -1, 4,  32'h18};
    tbl[3] = '{32'h2,   1'b0, 3'd1, 3'd5, 32'h0,         -1, 0,  3, 4,  32'h8};
    tbl[4] = '{32'h34,  1'b0, 3'd2, 3'd6, 32'h0,         15, 1, -1, 16, 32'h30};
    tbl[5] = '{32'h200, 1'b1, 3'd3, 3'd3, 32'hA0A0_A0A0,  0, 3, -1, 4,  32'h20C};
    tbl[6] = '{32'h80,  1'b0, 3'd0, 3'd1, 32'h0,          0, 2, -1, 1,  32'h80};
    tbl[7] = '{32'h3D,  1'b1, 3'd0, 3'd4, 32'h55AA_0000,  2, 1,  7, 8,  32'h3C};

    do_reset();
    check("rst_htrans", 32'(bus.HTRANS), 32'd0);
    check("rst_haddr", bus.HADDR, 32'd0);
    check("rst_hwdata", bus.HWDATA, 32'd0);
    check("rst_hsize", 32'(bus.HSIZE), 32'd0);
    check("rst_hburst", 32'(bus.HBURST), 32'd0);
    check1("rst_hwrite", bus.HWRITE, 1'b0);
    check1("rst_cmd_ready", bus.cmd_ready, 1'b1);
    check1("rst_wr_ack", bus.wr_ack, 1'b0);
    check1("rst_rd_valid", bus.rd_valid, 1'b0);
    check1("rst_done", bus.done, 1'b0);
    check1("rst_err", bus.err, 1'b0);

    for (int i = 0; i < 8; i++) run_cmd(tbl[i], 1'b0, 1'b0, tbl[i]);

    // Reset while the sixth beat of an INCR16 read is on the bus.
    bus.cmd_valid = 1'b1; bus.cmd_addr = 32'h400; bus.cmd_write = 1'b0;
    bus.cmd_size = 3'd2; bus.cmd_burst = 3'd7;
    @(posedge HCLK);
    @(negedge HCLK);
    bus.cmd_valid = 1'b0;
    repeat (5) @(negedge HCLK);
    check("rst_mid_pre_haddr", bus.HADDR, 32'h414);
    HRESET = 1'b1;
    @(posedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    check("rst_mid_htrans", 32'(bus.HTRANS), 32'd0);
    check1("rst_mid_cmd_ready", bus.cmd_ready, 1'b1);
    check1("rst_mid_done", bus.done, 1'b0);
    check1("rst_mid_err", bus.err, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      check1("rst_mid_no_done", bus.done | bus.err, 1'b0);
    end
    single = '{32'h88, 1'b1, 3'd2, 3'd0, 32'hCAFE_F00D, -1, 0, -1, 1, 32'h88};
    run_cmd(single, 1'b0, 1'b0, single);

    // Second command held on cmd_valid throughout an INCR4.
    b2b_a = '{32'h600, 1'b1, 3'd2, 3'd3, 32'h1000_0000, 2, 1, -1, 4, 32'h60C};
    b2b_b = '{32'h700, 1'b0, 3'd2, 3'd0, 32'h0,        -1, 0, -1, 1, 32'h700};
    run_cmd(b2b_a, 1'b0, 1'b1, b2b_b);
    run_cmd(b2b_b, 1'b0, 1'b0, b2b_b);

    for (int n = 0; n < 40; n++) begin
      r.burst = 3'($urandom_range(0, 7));
      r.size  = 3'($urandom_range(0, 3));
      r.write = 1'($urandom_range(0, 1));
      r.addr  = $urandom & ~((32'd1 << eff_size(r.size)) - 32'd1);
      r.wbase = $urandom;
      r.wbeat = -1;
      r.wcyc  = 0;
      r.ebeat = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, beats_of(r.burst) - 1)) : -1;
      r.exp_acc  = (r.ebeat < 0) ? beats_of(r.burst) : r.ebeat + 1;
      r.exp_last = model_addr(r.addr, r.size, r.burst, r.exp_acc - 1);
      run_cmd(r, 1'b1, 1'b0, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
